// File: rtl/mul_div_unit_if.sv
// Purpose: request/result bundle between the EX stage and the HI/LO multiply/divide unit.
// Latency: none, plain wires; the unit's timing is documented in mul_div_unit.
// Backpressure: busy from the unit; EX holds any start or Mfhi/Mflo while it is high.
// Signals: start/op/a/b/flush (EX -> unit), busy/done/hi/lo (unit -> EX/ALU read path).
// Modports: master = EX stage, slave = mul_div_unit.
interface mul_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// Purpose: iterative MULT/MULTU/DIV/DIVU (+ optional MADD/MSUB) unit owning the HI/LO pair.
// Latency: start edge to HI/LO written = 32/MUL_STEP+1 cycles (multiply), 33 cycles (divide); MTHI/MTLO 1 edge.
// Backpressure: busy high from the start edge until HI/LO are written; a start seen while busy is dropped.
// Ports: clk, reset_n (async active-low); mdu (slave): start, op[2:0], a, b, flush in; busy, done, hi, lo out.
// Parameter MUL_STEP (1,2,4,8): multiplier bits retired per cycle.
// Build macro MDU_MADD_EN: enables op 110 MADD / 111 MSUB (64-bit accumulate into HI/LO at FIXUP).
module mul_div_unit #(
  parameter int MUL_STEP = 1
) (
  input logic           clk,
  input logic           reset_n,
  mul_div_unit_if.slave mdu
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  localparam int         W          = 32 + MUL_STEP;
  localparam logic [5:0] MUL_CYCLES = 6'(32 / MUL_STEP);

  generate
    if (MUL_STEP != 1 && MUL_STEP != 2 && MUL_STEP != 4 && MUL_STEP != 8) begin : g_bad_step
      $error("mul_div_unit: MUL_STEP must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [63:0] acc;       // MUL: {partial product, remaining multiplier}; DIV: {remainder, quotient}
  logic [31:0] opnd;      // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic        neg_q;     // negate product / quotient at FIXUP
  logic        neg_r;     // negate remainder (dividend was negative)
  logic        div_zero;
  logic        is_div;
  logic [31:0] hi_q, lo_q;

  logic        issue, op_mul, op_div, op_sgn;
  logic [W-1:0] pp;
  logic [32:0] shifted, diff;
  logic [63:0] div_nxt, prod_s;
  logic [31:0] quo, rem, res_hi, res_lo;

`ifdef MDU_MADD_EN
  logic       acc_sub;    // MSUB rather than MADD
  logic       acc_en;     // accumulate into {hi,lo} at FIXUP
`endif

  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction

  // flush has priority over a start in the same IDLE cycle
  assign issue = (state == IDLE) && mdu.start && !mdu.flush;

  always_comb begin
    op_mul = (mdu.op == OP_MULT) || (mdu.op == OP_MULTU);
`ifdef MDU_MADD_EN
    op_mul = op_mul || (mdu.op == OP_MADD) || (mdu.op == OP_MSUB);
`endif
    op_div = (mdu.op == OP_DIV) || (mdu.op == OP_DIVU);
    op_sgn = (mdu.op == OP_MULT) || (mdu.op == OP_DIV) ||
             (mdu.op == OP_MADD) || (mdu.op == OP_MSUB);
  end

  // Multiply step: add multiplicand * low MUL_STEP multiplier bits into the upper half, shift right.
  assign pp = W'(acc[63:32]) + W'(opnd) * W'(acc[MUL_STEP-1:0]);

  // Restoring divide step: shift in next dividend bit, subtract divisor if it fits.
  // With a zero divisor both branches leave the same remainder, so it ends equal to |A|.
  assign shifted = {acc[63:32], acc[31]};
  assign diff    = shifted - {1'b0, opnd};
  assign div_nxt = diff[32] ? {shifted[31:0], acc[30:0], 1'b0}
                            : {diff[31:0],    acc[30:0], 1'b1};

  assign prod_s = neg_q ? -acc : acc;
  assign quo    = div_zero ? 32'hFFFF_FFFF : (neg_q ? -acc[31:0] : acc[31:0]);
  assign rem    = neg_r ? -acc[63:32] : acc[63:32];

  always_comb begin
    {res_hi, res_lo} = prod_s;
    if (is_div) begin
      {res_hi, res_lo} = {rem, quo};
    end
`ifdef MDU_MADD_EN
    else if (acc_en) begin
      {res_hi, res_lo} = acc_sub ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mdu.busy  = (state != IDLE);
    mdu.done  = 1'b0;
    case (state)
      IDLE: begin
        if (issue && op_mul)      state_nxt = MUL;
        else if (issue && op_div) state_nxt = DIV;
      end
      MUL, DIV: begin
        if (cnt == 6'd1) state_nxt = FIXUP;
      end
      FIXUP: begin
        state_nxt = IDLE;
        mdu.done  = !mdu.flush;
      end
      default: state_nxt = IDLE;
    endcase
    if (mdu.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
`ifdef MDU_MADD_EN
      acc_sub  <= 1'b0;
      acc_en   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            if (mdu.op == OP_MTHI) hi_q <= mdu.a;
            if (mdu.op == OP_MTLO) lo_q <= mdu.a;
            if (op_mul || op_div) begin
              neg_q    <= op_sgn && (mdu.a[31] ^ mdu.b[31]);
              neg_r    <= op_sgn && mdu.a[31];
              div_zero <= op_div && (mdu.b == 32'd0);
              is_div   <= op_div;
              cnt      <= op_div ? 6'd32 : MUL_CYCLES;
              opnd     <= op_div ? mag(mdu.b, op_sgn) : mag(mdu.a, op_sgn);
              acc      <= {32'd0, op_div ? mag(mdu.a, op_sgn) : mag(mdu.b, op_sgn)};
`ifdef MDU_MADD_EN
              acc_en   <= (mdu.op == OP_MADD) || (mdu.op == OP_MSUB);
              acc_sub  <= (mdu.op == OP_MSUB);
`endif
            end
          end
        end
        MUL: begin
          acc <= {pp, acc[31:MUL_STEP]};
          cnt <= cnt - 6'd1;
        end
        DIV: begin
          acc <= div_nxt;
          cnt <= cnt - 6'd1;
        end
        FIXUP: begin
          if (!mdu.flush) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign mdu.hi = hi_q;
  assign mdu.lo = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Purpose: directed-vector bench for mul_div_unit with hand-computed HI/LO results.
// Latency: checks 33-cycle busy window for MUL_STEP=1 multiplies and for divides.
// Backpressure: exercises start-while-busy, flush, and flush+start collisions.
module tb_mul_div_unit;
  localparam int         STEP     = 1;
  localparam int         MUL_CYC  = 32 / STEP + 1;
  localparam int         DIV_CYC  = 33;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_bad = 0;

  mul_div_unit_if mdu_if();

  mul_div_unit #(.MUL_STEP(STEP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mdu     (mdu_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mdu_if.start = 1'b1;
    mdu_if.op    = op;
    mdu_if.a     = a;
    mdu_if.b     = b;
    tick();
    mdu_if.start = 1'b0;
  endtask

  // Issue, count busy cycles and done pulses until idle (bounded), then check HI/LO.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_cyc);
    int cyc   = 0;
    int dones = 0;
    issue(op, a, b);
    while (mdu_if.busy && cyc < 200) begin
      if (mdu_if.done) dones++;
      tick();
      cyc++;
    end
    check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_done"}, dones, 1);
    check({tag, "_hi"}, mdu_if.hi, exp_hi);
    check({tag, "_lo"}, mdu_if.lo, exp_lo);
  endtask

  initial begin
    int dones;
    int cyc;
    reset_n      = 1'b0;
    mdu_if.start = 1'b0;
    mdu_if.op    = 3'b000;
    mdu_if.a     = '0;
    mdu_if.b     = '0;
    mdu_if.flush = 1'b0;
    #2;
    check("rst_busy", mdu_if.busy, 0);
    check("rst_done", mdu_if.done, 0);
    check("rst_hi", mdu_if.hi, 0);
    check("rst_lo", mdu_if.lo, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // multiplies, issued back-to-back in the IDLE cycle after each FIXUP
    run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_CYC);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_CYC);
    run_op("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MUL_CYC);

    // divides
    run_op("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYC);
    run_op("div_7dm2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_CYC);
    run_op("divu_5d0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV_CYC);
    run_op("div_m5d0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_CYC);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_CYC);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'h7FFF_FFFF, DIV_CYC);
    run_op("divu_100d7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_CYC);

    // MTLO / MTHI while idle
    issue(OP_MTLO, 32'h1234, 32'd0);
    check("mtlo_lo", mdu_if.lo, 32'h1234);
    check("mtlo_busy", mdu_if.busy, 0);
    check("mtlo_hi_kept", mdu_if.hi, 32'd2);
    issue(OP_MTHI, 32'hCAFE, 32'd0);
    check("mthi_hi", mdu_if.hi, 32'hCAFE);

    // MTLO while busy is dropped
    issue(OP_MULT, 32'd3, 32'd7);
    repeat (3) tick();
    issue(OP_MTLO, 32'h5555, 32'd0);
    check("mtlo_busy_lo", mdu_if.lo, 32'h1234);
    check("mtlo_busy_busy", mdu_if.busy, 1);
    cyc = 0;
    while (mdu_if.busy && cyc < 200) begin
      tick();
      cyc++;
    end
    check("mult_3x7_hi", mdu_if.hi, 32'd0);
    check("mult_3x7_lo", mdu_if.lo, 32'd21);

    // flush and start together in IDLE: nothing accepted
    mdu_if.flush = 1'b1;
    issue(OP_MULT, 32'd9, 32'd9);
    mdu_if.flush = 1'b0;
    check("flush_start_busy", mdu_if.busy, 0);
    tick();
    check("flush_start_busy2", mdu_if.busy, 0);
    check("flush_start_lo", mdu_if.lo, 32'd21);

    // DIV flushed at cycle 5
    dones = 0;
    issue(OP_DIV, 32'd100, 32'd3);
    for (int i = 0; i < 4; i++) begin
      if (mdu_if.done) dones++;
      tick();
    end
    mdu_if.flush = 1'b1;
    tick();
    mdu_if.flush = 1'b0;
    check("div_flush_busy", mdu_if.busy, 0);
    for (int i = 0; i < 40; i++) begin
      if (mdu_if.done) dones++;
      tick();
    end
    check("div_flush_done", dones, 0);
    check("div_flush_hi", mdu_if.hi, 32'd0);
    check("div_flush_lo", mdu_if.lo, 32'd21);

`ifdef MDU_MADD_EN
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
    run_op("madd_1x1", OP_MADD, 32'd1, 32'd1, 32'd1, 32'd0, MUL_CYC);
    run_op("msub_2x3", OP_MSUB, 32'd2, 32'd3, 32'd0, 32'hFFFF_FFFA, MUL_CYC);
    run_op("madd_m1x1", OP_MADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFF9, MUL_CYC);
`else
    issue(OP_MADD, 32'd5, 32'd6);
    check("madd_off_busy", mdu_if.busy, 0);
    issue(OP_MSUB, 32'd5, 32'd6);
    check("msub_off_busy", mdu_if.busy, 0);
    tick();
    check("madd_off_busy2", mdu_if.busy, 0);
    check("madd_off_hi", mdu_if.hi, 32'd0);
    check("madd_off_lo", mdu_if.lo, 32'd21);
`endif

    // reset in the middle of a MULT
    issue(OP_MULT, 32'd3, 32'd7);
    repeat (9) tick();
    check("pre_rst_busy", mdu_if.busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", mdu_if.busy, 0);
    check("mid_rst_done", mdu_if.done, 0);
    check("mid_rst_hi", mdu_if.hi, 0);
    check("mid_rst_lo", mdu_if.lo, 0);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    check("post_rst_busy", mdu_if.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
